// File: rtl/ppi_pkg.sv
// Shared types for the multiport PPI: port mode encoding and status-register
// bit positions.
package ppi_pkg;

  typedef enum logic [1:0] {
    PPI_IN      = 2'b00,
    PPI_OUT     = 2'b01,
    PPI_STB_IN  = 2'b10,
    PPI_STB_OUT = 2'b11
  } ppi_mode_e;

  localparam int ST_OVR  = 7;
  localparam int ST_BUF  = 6;
  localparam int ST_INTR = 4;
  localparam int ST_INTE = 3;

endpackage

// File: rtl/ppi_port_ch.sv
// One PPI peripheral port: input/output latches, strobe handshakes and flags.
// Optional feature macro: PPI_INTR_EN (interrupt enable and request).
module ppi_port_ch
  import ppi_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          wr_ctl_i,
  input  logic          wr_data_i,
  input  logic          rd_data_i,
  input  logic [2:0]    ctl_i,
  input  logic [PW-1:0] wdata_i,
  input  logic [PW-1:0] pin_i,
  input  logic          nstb_i,
  input  logic          nack_i,
  output logic [PW-1:0] pout_o,
  output logic          pen_o,
  output logic          ibf_o,
  output logic          nobf_o,
  output logic          intr_o,
  output logic [7:0]    status_o,
  output logic [PW-1:0] rdata_o
);

  ppi_mode_e     mode_q, mode_d;
  logic          inte_q, inte_d;
  logic [PW-1:0] pout_q, pout_d;
  logic [PW-1:0] lat_q, lat_d;
  logic          ibf_q, ibf_d, obf_q, obf_d, intr_q, intr_d, ovr_q, ovr_d;
  logic [2:0]    stb_q, ack_q;
  logic [PW-1:0] pin_s1_q, pin_s2_q;
  logic          stb_fall, stb_rise, ack_fall, ack_rise;

  // Strobe synchronizers idle high so reset release never looks like an edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stb_q    <= 3'b111;
      ack_q    <= 3'b111;
      pin_s1_q <= '0;
      pin_s2_q <= '0;
    end else begin
      stb_q    <= {stb_q[1:0], nstb_i};
      ack_q    <= {ack_q[1:0], nack_i};
      pin_s1_q <= pin_i;
      pin_s2_q <= pin_s1_q;
    end
  end

  assign stb_fall = stb_q[2] & ~stb_q[1];
  assign stb_rise = ~stb_q[2] & stb_q[1];
  assign ack_fall = ack_q[2] & ~ack_q[1];
  assign ack_rise = ~ack_q[2] & ack_q[1];

  always_comb begin
    mode_d = mode_q;
    inte_d = inte_q;
    pout_d = pout_q;
    lat_d  = lat_q;
    ibf_d  = ibf_q;
    obf_d  = obf_q;
    intr_d = intr_q;
    ovr_d  = ovr_q;
    if (wr_ctl_i) begin
      mode_d = ppi_mode_e'(ctl_i[1:0]);
      inte_d = ctl_i[2];
      ibf_d  = 1'b0;
      obf_d  = 1'b0;
      intr_d = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      case (mode_q)
        PPI_OUT: if (wr_data_i) pout_d = wdata_i;
        PPI_STB_IN: begin
          if (rd_data_i) begin
            ibf_d  = 1'b0;
            intr_d = 1'b0;
          end
          // A buffer being read out this cycle counts as empty: the new byte wins.
          if (stb_fall) begin
            if (ibf_q && !rd_data_i) ovr_d = 1'b1;
            else begin
              lat_d = pin_s2_q;
              ibf_d = 1'b1;
            end
          end
          if (stb_rise && ibf_q && inte_q) intr_d = 1'b1;
        end
        PPI_STB_OUT: begin
          if (ack_fall) obf_d = 1'b0;
          if (wr_data_i) begin
            pout_d = wdata_i;
            obf_d  = 1'b1;
            intr_d = 1'b0;
          end
          if (ack_rise && !obf_q && inte_q) intr_d = 1'b1;
        end
        default: ;
      endcase
    end
`ifndef PPI_INTR_EN
    inte_d = 1'b0;
    intr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mode_q <= PPI_IN;
      inte_q <= 1'b0;
      pout_q <= '0;
      lat_q  <= '0;
      ibf_q  <= 1'b0;
      obf_q  <= 1'b0;
      intr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      inte_q <= inte_d;
      pout_q <= pout_d;
      lat_q  <= lat_d;
      ibf_q  <= ibf_d;
      obf_q  <= obf_d;
      intr_q <= intr_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    status_o          = '0;
    status_o[ST_OVR]  = ovr_q;
    status_o[ST_BUF]  = ibf_q | obf_q;
    status_o[ST_INTR] = intr_q;
    status_o[ST_INTE] = inte_q;
    status_o[1:0]     = mode_q;
  end

  always_comb begin
    case (mode_q)
      PPI_IN:     rdata_o = pin_s2_q;
      PPI_STB_IN: rdata_o = lat_q;
      default:    rdata_o = pout_q;
    endcase
  end

  assign pout_o = pout_q;
  assign pen_o  = (mode_q == PPI_OUT) || (mode_q == PPI_STB_OUT);
  assign ibf_o  = ibf_q;
  assign nobf_o = ~obf_q;
  assign intr_o = intr_q;

endmodule

// File: rtl/ppi_multiport.sv
// Multiport programmable peripheral interface: synchronous CPU bus decode and
// NPORTS ppi_port_ch channels. Optional feature macro: PPI_INTR_EN.
module ppi_multiport
  import ppi_pkg::*;
#(
  parameter  int NPORTS = 3,
  parameter  int PW     = 8,
  localparam int AW     = $clog2(NPORTS) + 1
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               nCS,
  input  logic               nRD,
  input  logic               nWR,
  input  logic [AW-1:0]      A,
  input  logic [7:0]         Din,
  output logic [7:0]         Dout,
  output logic               DEn,
  input  logic [NPORTS*PW-1:0] PIn,
  output logic [NPORTS*PW-1:0] POut,
  output logic [NPORTS-1:0]  PEn,
  input  logic [NPORTS-1:0]  nSTB,
  input  logic [NPORTS-1:0]  nACK,
  output logic [NPORTS-1:0]  IBF,
  output logic [NPORTS-1:0]  nOBF,
  output logic [NPORTS-1:0]  INTR
);

  localparam int NSLOT = 1 << (AW - 1);

  logic [1:0]    nwr_q, nrd_q;
  logic          ncs_q;
  logic          wr_stb, rd_done, is_ctl;
  logic [AW-2:0] idx;
  logic [7:0]    st_w [NSLOT];
  logic [7:0]    rd_w [NSLOT];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      nwr_q <= 2'b11;
      nrd_q <= 2'b11;
      ncs_q <= 1'b1;
    end else begin
      nwr_q <= {nwr_q[0], nWR};
      nrd_q <= {nrd_q[0], nRD};
      ncs_q <= nCS;
    end
  end

  assign wr_stb  = nwr_q[1] & ~nwr_q[0] & ~ncs_q;
  assign rd_done = ~nrd_q[1] & nrd_q[0] & ~ncs_q;
  assign is_ctl  = A[AW-1];
  assign idx     = A[AW-2:0];

  // Unpopulated address slots read back as zero and swallow writes.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NPORTS) begin : g_ch
      logic          sel;
      logic [PW-1:0] rdata;
      assign sel = (idx == (AW-1)'(i));
      ppi_port_ch #(.PW(PW)) u_ch (
        .clk      (clk),
        .nReset   (nReset),
        .wr_ctl_i (wr_stb & sel & is_ctl),
        .wr_data_i(wr_stb & sel & ~is_ctl),
        .rd_data_i(rd_done & sel & ~is_ctl),
        .ctl_i    (Din[2:0]),
        .wdata_i  (Din[PW-1:0]),
        .pin_i    (PIn[i*PW +: PW]),
        .nstb_i   (nSTB[i]),
        .nack_i   (nACK[i]),
        .pout_o   (POut[i*PW +: PW]),
        .pen_o    (PEn[i]),
        .ibf_o    (IBF[i]),
        .nobf_o   (nOBF[i]),
        .intr_o   (INTR[i]),
        .status_o (st_w[i]),
        .rdata_o  (rdata)
      );
      assign rd_w[i] = 8'(rdata);
    end else begin : g_empty
      assign st_w[i] = 8'h00;
      assign rd_w[i] = 8'h00;
    end
  end

  assign DEn  = ~nCS & ~nRD;
  assign Dout = is_ctl ? st_w[idx] : rd_w[idx];

endmodule

// File: tb/tb_ppi_multiport.sv
// Directed self-checking bench for ppi_multiport (3 ports x 8 bits); expected
// interrupt behaviour follows whether PPI_INTR_EN is defined.
module tb_ppi_multiport;

`ifdef PPI_INTR_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nReset, nCS, nRD, nWR;
  logic [2:0]  A;
  logic [7:0]  Din, Dout;
  logic        DEn;
  logic [23:0] PIn, POut;
  logic [2:0]  PEn, nSTB, nACK, IBF, nOBF, INTR;
  logic [7:0]  rd;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ppi_multiport #(.NPORTS(3), .PW(8)) dut (
    .clk(clk), .nReset(nReset), .nCS(nCS), .nRD(nRD), .nWR(nWR), .A(A),
    .Din(Din), .Dout(Dout), .DEn(DEn), .PIn(PIn), .POut(POut), .PEn(PEn),
    .nSTB(nSTB), .nACK(nACK), .IBF(IBF), .nOBF(nOBF), .INTR(INTR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    A = a; Din = d; nCS = 1'b0;
    @(negedge clk);
    nWR = 1'b0;
    cycles(3);
    nWR = 1'b1;
    @(negedge clk);
    nCS = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    A = a; nCS = 1'b0; nRD = 1'b0;
    cycles(2);
    d = Dout;
    nRD = 1'b1;
    cycles(3);
    nCS = 1'b1;
  endtask

  initial begin
    nReset = 1'b0; nCS = 1'b1; nRD = 1'b1; nWR = 1'b1; A = '0; Din = '0;
    PIn = '0; nSTB = 3'b111; nACK = 3'b111;
    cycles(3);
    check("rst_pen", PEn, 3'b000);
    check("rst_nobf", nOBF, 3'b111);
    check("rst_intr", INTR, 3'b000);
    check("rst_pout", POut, 24'h0);
    nReset = 1'b1;
    cycles(2);
    bus_read(3'b101, rd);
    check("ctl1_reset", rd, 8'h00);

    // Basic output on port 0
    bus_write(3'b100, 8'h01);
    check("pen0", PEn, 3'b001);
    bus_write(3'b000, 8'hA5);
    check("pout0", POut[7:0], 8'hA5);
    bus_read(3'b100, rd);
    check("stat0", rd, 8'h01);

    // Basic input on port 1, with DEn observed mid-read
    PIn[15:8] = 8'h96;
    cycles(4);
    @(negedge clk);
    A = 3'b001; nCS = 1'b0; nRD = 1'b0;
    cycles(2);
    check("den", DEn, 1'b1);
    check("basic_in1", Dout, 8'h96);
    nRD = 1'b1;
    cycles(3);
    nCS = 1'b1;
    check("den_off", DEn, 1'b0);

    // Strobed input on port 1
    bus_write(3'b101, 8'h06);
    PIn[15:8] = 8'h3C;
    cycles(4);
    nSTB[1] = 1'b0;
    cycles(4);
    check("ibf1_set", IBF[1], 1'b1);
    check("intr1_pre_rise", INTR[1], 1'b0);
    nSTB[1] = 1'b1;
    cycles(4);
    check("intr1_rise", INTR[1], IE);
    bus_read(3'b101, rd);
    check("stat1_full", rd, IE ? 8'h5A : 8'h42);
    bus_read(3'b001, rd);
    check("stb_in_data", rd, 8'h3C);
    check("ibf1_clr", IBF[1], 1'b0);
    check("intr1_clr", INTR[1], 1'b0);

    // Overrun: second strobe carries 0x77 before the read
    nSTB[1] = 1'b0; cycles(4); nSTB[1] = 1'b1; cycles(4);
    PIn[15:8] = 8'h77;
    cycles(4);
    nSTB[1] = 1'b0; cycles(4); nSTB[1] = 1'b1; cycles(4);
    bus_read(3'b101, rd);
    check("stat1_ovr", rd, IE ? 8'hDA : 8'hC2);
    bus_read(3'b001, rd);
    check("ovr_keeps_data", rd, 8'h3C);
    bus_read(3'b101, rd);
    check("stat1_sticky", rd, IE ? 8'h8A : 8'h82);

    // Strobed output on port 2
    bus_write(3'b110, 8'h07);
    check("pen_all", PEn, 3'b101);
    check("nobf_after_ctl", nOBF, 3'b111);
    bus_write(3'b010, 8'h5A);
    check("nobf2_set", nOBF, 3'b011);
    check("pout2", POut[23:16], 8'h5A);
    nACK[2] = 1'b0;
    cycles(4);
    check("nobf2_ack", nOBF[2], 1'b1);
    check("intr2_pre_rise", INTR[2], 1'b0);
    nACK[2] = 1'b1;
    cycles(4);
    check("intr2_rise", INTR[2], IE);
    bus_write(3'b010, 8'h11);
    check("intr2_clr", INTR[2], 1'b0);
    check("nobf2_reset", nOBF[2], 1'b0);
    check("pout2_new", POut[23:16], 8'h11);

    // Out-of-range index
    bus_write(3'b011, 8'hFF);
    check("oor_no_effect", POut, 24'h11_00_A5);
    bus_read(3'b011, rd);
    check("oor_data", rd, 8'h00);
    bus_read(3'b111, rd);
    check("oor_stat", rd, 8'h00);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    check("arst_pout", POut, 24'h0);
    check("arst_pen", PEn, 3'b000);
    check("arst_nobf", nOBF, 3'b111);
    cycles(2);
    nReset = 1'b1;
    cycles(4);
    check("post_rst_ibf", IBF, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
